// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the MEM pipeline stage and data memory.
// The master drives the request; the slave answers with ack and read data.
interface mem_stage_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, output we, output addr, output wdata, input ack, input rdata);
    modport slave  (input req, input we, input addr, input wdata, output ack, output rdata);
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM register, branch resolution, and load/store over a req/ack bus.
// Optional MEM_STALL_STATS_EN adds perf_stall_cnt, a wrapping count of stall cycles.
module mem_stage #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_wreg,
    input  logic        ex_m2reg,
    input  logic        ex_wmem,
    input  logic        ex_branch,
    input  logic        ex_zero,
    input  logic [31:0] ex_aluR,
    input  logic [31:0] ex_inB,
    input  logic [31:0] ex_pc,
    input  logic [4:0]  ex_destR,
    input  logic [3:0]  EXE_ins_type,
    input  logic [3:0]  EXE_ins_number,
    output logic        mem_wreg,
    output logic        mem_m2reg,
    output logic [31:0] mem_aluR,
    output logic [31:0] mem_mdata,
    output logic [4:0]  mem_destR,
    output logic        mem_pcsrc,
    output logic [31:0] mem_pc,
    output logic        mem_stall,
    output logic        mem_err,
    output logic [3:0]  MEM_ins_type,
    output logic [3:0]  MEM_ins_number,
    mem_stage_if.master dmem
`ifdef MEM_STALL_STATS_EN
    ,
    output logic [31:0] perf_stall_cnt
`endif
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StAccess = 2'd1;
    localparam logic [1:0] StDone   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_wmem, mem_branch, mem_zero;
    logic [31:0]      mem_inB;
    logic             in_access, timeout_hit;

    assign in_access   = (state_q == StAccess);
    // Ack on the final allowed cycle still completes the access normally.
    assign timeout_hit = in_access && !dmem.ack && (cnt_q == CNT_W'(TIMEOUT - 1));

    assign mem_stall  = in_access;
    assign mem_pcsrc  = mem_branch & mem_zero;
    assign dmem.req   = in_access;
    assign dmem.we    = in_access & mem_wmem;
    assign dmem.addr  = mem_aluR;
    assign dmem.wdata = mem_inB;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle, StDone: begin
                if (ex_m2reg || ex_wmem) begin
                    state_d = StAccess;
                    cnt_d   = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            StAccess: begin
                if (dmem.ack || timeout_hit) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // EX/MEM register; frozen while an access is pending.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_wreg       <= 1'b0;
            mem_m2reg      <= 1'b0;
            mem_wmem       <= 1'b0;
            mem_branch     <= 1'b0;
            mem_zero       <= 1'b0;
            mem_aluR       <= '0;
            mem_inB        <= '0;
            mem_pc         <= '0;
            mem_destR      <= '0;
            MEM_ins_type   <= '0;
            MEM_ins_number <= '0;
        end else if (!mem_stall) begin
            mem_wreg       <= ex_wreg;
            mem_m2reg      <= ex_m2reg;
            mem_wmem       <= ex_wmem;
            mem_branch     <= ex_branch;
            mem_zero       <= ex_zero;
            mem_aluR       <= ex_aluR;
            mem_inB        <= ex_inB;
            mem_pc         <= ex_pc;
            mem_destR      <= ex_destR;
            MEM_ins_type   <= EXE_ins_type;
            MEM_ins_number <= EXE_ins_number;
        end else if (timeout_hit) begin
            mem_wreg <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            mem_err   <= 1'b0;
            mem_mdata <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (in_access && dmem.ack) begin
                // A combined m2reg+wmem op behaves as a store and leaves mdata alone.
                if (mem_m2reg && !mem_wmem) mem_mdata <= dmem.rdata;
            end else if (timeout_hit) begin
                mem_err   <= 1'b1;
                mem_mdata <= '0;
            end
        end
    end

`ifdef MEM_STALL_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_cnt <= '0;
        end else if (mem_stall) begin
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule
